// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter
//   Two-requester round-robin arbiter that sequences I2C transactions
//   (address byte, 1-4 data bytes, STOP) through an external byte engine.
//
// Ports
//   clk, reset        : clock, synchronous active-low reset
//   req[1:0]          : transaction requests, bit N = requester N
//   addr[13:0]        : {addr1, addr0}, 7-bit slave addresses
//   rw[1:0]           : per requester, 1 = read, 0 = write
//   len[3:0]          : {len1, len0}, byte count minus 1
//   wdata[63:0]       : {wdata1, wdata0}, byte 0 in bits [7:0], sent first
//   gnt[1:0]          : one-hot owner of the current transaction
//   done[1:0], err[1:0] : one-cycle completion / error pulses
//   rdata[31:0]       : read bytes, byte i in bits [8i+7:8i]
//   busy              : state is not IDLE
//   eng_go + eng_start/stop/rd/mack/tx : command strobe and fields
//   eng_done, eng_rx, eng_nack : engine completion, read byte, slave NACK
module i2c_bus_arbiter #(
  parameter int TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [13:0] addr,
  input  logic [1:0]  rw,
  input  logic [3:0]  len,
  input  logic [63:0] wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        eng_go,
  output logic        eng_start,
  output logic        eng_stop,
  output logic        eng_rd,
  output logic        eng_mack,
  output logic [7:0]  eng_tx,
  input  logic        eng_done,
  input  logic [7:0]  eng_rx,
  input  logic        eng_nack
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, XFER, STOP, FIN} state_t;

  state_t state, nxt;

  // latched transaction
  logic        owner, owner_n;
  logic [6:0]  a_q, a_n;
  logic        rw_q, rw_n;
  logic [1:0]  len_q, len_n;
  logic [31:0] wd_q, wd_n;

  // sequencing
  logic        last, last_n;       // requester granted most recently
  logic        waiting, waiting_n; // command issued, awaiting eng_done
  logic [1:0]  idx, idx_n;
  logic        eflag, eflag_n;
  logic [CW-1:0] cnt, cnt_n;

  // registered outputs
  logic [1:0]  gnt_n, done_n, err_n;
  logic [31:0] rdata_n;
  logic        go_n, start_n, stop_n, rd_n, mack_n;
  logic [7:0]  tx_n;

  // command issue requests from the state logic
  logic        iss_addr, iss_byte, iss_stop, to_fin;
  logic [1:0]  bi;
  logic        win, wait_ev;

  // On contention the requester not served last wins; last resets to 1
  // so requester 0 has priority out of reset.
  assign win     = (req == 2'b11) ? ~last : req[1];
  // eng_done is meaningless in the same cycle as our own eng_go
  assign wait_ev = waiting && !eng_go;
  assign busy    = (state != IDLE);

  always_comb begin
    nxt       = state;
    owner_n   = owner;
    a_n       = a_q;
    rw_n      = rw_q;
    len_n     = len_q;
    wd_n      = wd_q;
    last_n    = last;
    waiting_n = waiting;
    idx_n     = idx;
    eflag_n   = eflag;
    cnt_n     = cnt;
    gnt_n     = gnt;
    rdata_n   = rdata;
    done_n    = 2'b00;
    err_n     = 2'b00;
    go_n      = 1'b0;
    start_n   = 1'b0;
    stop_n    = 1'b0;
    rd_n      = 1'b0;
    mack_n    = 1'b0;
    tx_n      = 8'h00;
    iss_addr  = 1'b0;
    iss_byte  = 1'b0;
    iss_stop  = 1'b0;
    to_fin    = 1'b0;
    bi        = 2'd0;

    case (state)
      IDLE: begin
        if (|req) begin
          owner_n   = win;
          gnt_n     = win ? 2'b10 : 2'b01;
          a_n       = win ? addr[13:7]   : addr[6:0];
          rw_n      = win ? rw[1]        : rw[0];
          len_n     = win ? len[3:2]     : len[1:0];
          wd_n      = win ? wdata[63:32] : wdata[31:0];
          if (win ? rw[1] : rw[0]) rdata_n = 32'h0;
          idx_n     = 2'd0;
          eflag_n   = 1'b0;
          waiting_n = 1'b0;
          nxt       = ADDR;
        end
      end
      ADDR: begin
        if (!waiting) begin
          iss_addr = 1'b1;
        end else if (wait_ev && eng_done) begin
          if (eng_nack) begin
            eflag_n  = 1'b1;
            iss_stop = 1'b1;
            nxt      = STOP;
          end else begin
            idx_n    = 2'd0;
            bi       = 2'd0;
            iss_byte = 1'b1;
            nxt      = XFER;
          end
        end
      end
      XFER: begin
        if (wait_ev && eng_done) begin
          if (rw_q) rdata_n[{idx, 3'b000} +: 8] = eng_rx;
          if (idx == len_q) begin
            // STOP already rode on the last byte, so a NACK here just errors
            if (!rw_q && eng_nack) eflag_n = 1'b1;
            to_fin = 1'b1;
          end else if (!rw_q && eng_nack) begin
            eflag_n  = 1'b1;
            iss_stop = 1'b1;
            nxt      = STOP;
          end else begin
            idx_n    = idx + 2'd1;
            bi       = idx + 2'd1;
            iss_byte = 1'b1;
          end
        end
      end
      STOP: begin
        if (wait_ev && eng_done) to_fin = 1'b1;
      end
      FIN: begin
        gnt_n     = 2'b00;
        last_n    = owner;
        waiting_n = 1'b0;
        nxt       = IDLE;
      end
      default: nxt = IDLE;
    endcase

    // Timeout: abandon the transaction without a STOP
    if (wait_ev && !eng_done && state != IDLE && state != FIN) begin
      if (cnt == TLIM) begin
        eflag_n = 1'b1;
        to_fin  = 1'b1;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end

    if (iss_addr) begin
      go_n    = 1'b1;
      start_n = 1'b1;
      tx_n    = {a_q, rw_q};
    end
    if (iss_byte) begin
      go_n   = 1'b1;
      rd_n   = rw_q;
      tx_n   = rw_q ? 8'h00 : wd_q[{bi, 3'b000} +: 8];
      stop_n = (bi == len_q);
      mack_n = rw_q && (bi == len_q);
    end
    if (iss_stop) begin
      go_n   = 1'b1;
      stop_n = 1'b1;
    end
    if (go_n) begin
      waiting_n = 1'b1;
      cnt_n     = '0;
    end
    if (to_fin) begin
      nxt       = FIN;
      waiting_n = 1'b0;
      done_n    = owner ? 2'b10 : 2'b01;
      err_n     = eflag_n ? (owner ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      a_q       <= '0;
      rw_q      <= 1'b0;
      len_q     <= '0;
      wd_q      <= '0;
      last      <= 1'b1;
      waiting   <= 1'b0;
      idx       <= '0;
      eflag     <= 1'b0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      eng_go    <= 1'b0;
      eng_start <= 1'b0;
      eng_stop  <= 1'b0;
      eng_rd    <= 1'b0;
      eng_mack  <= 1'b0;
      eng_tx    <= '0;
    end else begin
      state     <= nxt;
      owner     <= owner_n;
      a_q       <= a_n;
      rw_q      <= rw_n;
      len_q     <= len_n;
      wd_q      <= wd_n;
      last      <= last_n;
      waiting   <= waiting_n;
      idx       <= idx_n;
      eflag     <= eflag_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      done      <= done_n;
      err       <= err_n;
      rdata     <= rdata_n;
      eng_go    <= go_n;
      eng_start <= start_n;
      eng_stop  <= stop_n;
      eng_rd    <= rd_n;
      eng_mack  <= mack_n;
      eng_tx    <= tx_n;
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
module tb_i2c_bus_arbiter;
  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [13:0] addr = '0;
  logic [1:0]  rw = '0;
  logic [3:0]  len = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  gnt, done, err;
  logic [31:0] rdata;
  logic        busy, eng_go, eng_start, eng_stop, eng_rd, eng_mack;
  logic [7:0]  eng_tx;
  logic        eng_done = 1'b0;
  logic [7:0]  eng_rx = '0;
  logic        eng_nack = 1'b0;

  i2c_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .rw(rw), .len(len),
    .wdata(wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .busy(busy), .eng_go(eng_go), .eng_start(eng_start), .eng_stop(eng_stop),
    .eng_rd(eng_rd), .eng_mack(eng_mack), .eng_tx(eng_tx),
    .eng_done(eng_done), .eng_rx(eng_rx), .eng_nack(eng_nack)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic start, stop, rd, mack; logic [7:0] tx;} cmd_t;
  typedef struct packed {logic [1:0] d, e; logic [31:0] rd;} fin_t;

  cmd_t       exp_cmd[$];
  fin_t       exp_fin[$];
  logic [7:0] rx_q[$];

  int checks = 0;
  int failures = 0;

  // engine model knobs
  int eng_delay = 0;
  int nack_at = -1;
  int cmd_total = 0;
  bit hang = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic pc(input logic s, input logic p, input logic r, input logic m, input logic [7:0] t);
    cmd_t c;
    c = '{start: s, stop: p, rd: r, mack: m, tx: t};
    exp_cmd.push_back(c);
  endtask

  task automatic pf(input logic [1:0] d, input logic [1:0] e, input logic [31:0] r);
    fin_t f;
    f = '{d: d, e: e, rd: r};
    exp_fin.push_back(f);
  endtask

  // byte engine: eng_done arrives eng_delay cycles after the cycle following eng_go
  initial begin
    forever begin
      if (reset && eng_go === 1'b1 && !hang) begin
        int n;
        logic [7:0] r;
        n = cmd_total;
        cmd_total++;
        r = 8'h00;
        if (eng_rd && rx_q.size() > 0) r = rx_q.pop_front();
        repeat (eng_delay + 1) begin @(posedge clk); #1; end
        eng_done = 1'b1;
        eng_rx   = r;
        eng_nack = (n == nack_at);
        @(posedge clk); #1;
        eng_done = 1'b0;
        eng_rx   = 8'h00;
        eng_nack = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("gnt_onehot0", {63'h0, $onehot0(gnt)}, 64'h1);
        if (eng_go) begin
          if (exp_cmd.size() == 0) chk("unexpected_cmd", {52'h0, eng_start, eng_stop, eng_rd, eng_mack, eng_tx}, 64'h0);
          else begin
            cmd_t c;
            c = exp_cmd.pop_front();
            chk("cmd", {52'h0, eng_start, eng_stop, eng_rd, eng_mack, eng_tx}, {52'h0, c});
          end
        end
        if (|done) begin
          if (exp_fin.size() == 0) chk("unexpected_done", {62'h0, done}, 64'h0);
          else begin
            fin_t f;
            f = exp_fin.pop_front();
            chk("done", {62'h0, done}, {62'h0, f.d});
            chk("err", {62'h0, err}, {62'h0, f.e});
            chk("rdata", {32'h0, rdata}, {32'h0, f.rd});
            chk("gnt_at_done", {62'h0, gnt}, {62'h0, f.d});
          end
        end else if (|err) begin
          chk("err_without_done", {62'h0, err}, 64'h0);
        end
      end
    end
  end

  task automatic run_txn(input int w, input logic [6:0] a, input logic r,
                         input logic [1:0] l, input logic [31:0] wd);
    @(negedge clk);
    req   = 2'b01 << w;
    addr  = (w == 1) ? {a, 7'h0} : {7'h0, a};
    rw    = (w == 1) ? {r, 1'b0} : {1'b0, r};
    len   = (w == 1) ? {l, 2'b00} : {2'b00, l};
    wdata = (w == 1) ? {wd, 32'h0} : {32'h0, wd};
    for (int i = 0; i < 10 && gnt[w] !== 1'b1; i++) @(negedge clk);
    chk("grant", {62'h0, gnt}, {62'h0, 2'b01 << w});
    // inputs change after latching; the transaction must not notice
    req = 2'b00; addr = ~addr; wdata = ~wdata; rw = ~rw; len = ~len;
    for (int i = 0; i < TO + 60 && done == 2'b00; i++) @(negedge clk);
    chk("done_seen", {63'h0, |done}, 64'h1);
    @(negedge clk);
  endtask

  initial begin
    // reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {gnt, done, err, busy, eng_go, eng_start, eng_stop, eng_rd, eng_mack, eng_tx},
        '0);
    chk("rst_rdata", {32'h0, rdata}, 64'h0);
    reset = 1'b1;
    @(negedge clk);

    // minimum latency, 1-byte write, zero-delay engine
    pc(1, 0, 0, 0, 8'h4E); pc(0, 1, 0, 0, 8'h5A); pf(2'b01, 2'b00, 32'h0);
    req = 2'b01; addr = {7'h0, 7'h27}; rw = 2'b00; len = 4'h0; wdata = {32'h0, 32'h5A};
    @(negedge clk);
    chk("lat_gnt", {62'h0, gnt}, 64'h1);
    req = 2'b00;
    @(negedge clk); chk("lat_addr_go", {63'h0, eng_go}, 64'h1);
    @(negedge clk); chk("lat_gap", {63'h0, eng_go}, 64'h0);
    @(negedge clk); chk("lat_data_go", {63'h0, eng_go}, 64'h1);
    @(negedge clk);
    @(negedge clk); chk("lat_done", {62'h0, done}, 64'h1);
    @(negedge clk); chk("idle_after_fin", {63'h0, busy}, 64'h0);

    // 2-byte write
    pc(1, 0, 0, 0, 8'h4E); pc(0, 0, 0, 0, 8'h5A); pc(0, 1, 0, 0, 8'hA5);
    pf(2'b01, 2'b00, 32'h0);
    run_txn(0, 7'h27, 1'b0, 2'd1, 32'h0000A55A);

    // 2-byte read on requester 1
    eng_delay = 2;
    rx_q.push_back(8'h19); rx_q.push_back(8'h80);
    pc(1, 0, 0, 0, 8'h91); pc(0, 0, 1, 0, 8'h00); pc(0, 1, 1, 1, 8'h00);
    pf(2'b10, 2'b00, 32'h00008019);
    run_txn(1, 7'h48, 1'b1, 2'd1, 32'h0);

    // 1-byte read clears the upper bytes
    eng_delay = 0;
    rx_q.push_back(8'h33);
    pc(1, 0, 0, 0, 8'h45); pc(0, 1, 1, 1, 8'h00);
    pf(2'b01, 2'b00, 32'h00000033);
    run_txn(0, 7'h22, 1'b1, 2'd0, 32'h0);

    // write leaves rdata alone
    pc(1, 0, 0, 0, 8'hA0); pc(0, 1, 0, 0, 8'h77);
    pf(2'b10, 2'b00, 32'h00000033);
    run_txn(1, 7'h50, 1'b0, 2'd0, 32'h00000077);

    // address NACK: stop-only command, then done+err
    nack_at = cmd_total;
    pc(1, 0, 0, 0, 8'h20); pc(0, 1, 0, 0, 8'h00);
    pf(2'b01, 2'b01, 32'h00000033);
    run_txn(0, 7'h10, 1'b0, 2'd3, 32'h44332211);

    // data NACK on a non-last byte
    nack_at = cmd_total + 1;
    pc(1, 0, 0, 0, 8'h0A); pc(0, 0, 0, 0, 8'hAA); pc(0, 1, 0, 0, 8'h00);
    pf(2'b10, 2'b10, 32'h00000033);
    run_txn(1, 7'h05, 1'b0, 2'd2, 32'h00CCBBAA);

    // data NACK on the last byte: no extra STOP
    nack_at = cmd_total + 1;
    pc(1, 0, 0, 0, 8'hFE); pc(0, 1, 0, 0, 8'h11);
    pf(2'b01, 2'b01, 32'h00000033);
    run_txn(0, 7'h7F, 1'b0, 2'd0, 32'h00000011);
    nack_at = -1;

    // contention from reset: 0,1,0,1
    eng_delay = 1;
    reset = 1'b0;
    req = 2'b11; addr = {7'h02, 7'h01}; rw = 2'b00; len = 4'h0;
    wdata = {32'h02, 32'h01};
    for (int k = 0; k < 2; k++) begin
      pc(1, 0, 0, 0, 8'h02); pc(0, 1, 0, 0, 8'h01); pf(2'b01, 2'b00, 32'h0);
      pc(1, 0, 0, 0, 8'h04); pc(0, 1, 0, 0, 8'h02); pf(2'b10, 2'b00, 32'h0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    begin
      int nd;
      nd = 0;
      for (int i = 0; i < 200 && nd < 4; i++) begin
        @(negedge clk);
        if (|done) nd++;
      end
      req = 2'b00;
      chk("contention_count", nd, 4);
    end
    @(negedge clk);

    // timeout: engine never answers
    eng_delay = 0;
    hang = 1'b1;
    pc(1, 0, 0, 0, 8'h06); pf(2'b01, 2'b01, 32'h0);
    run_txn(0, 7'h03, 1'b0, 2'd0, 32'h0);
    chk("timeout_idle", {63'h0, busy}, 64'h0);
    hang = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of XFER
    eng_delay = 3;
    pc(1, 0, 0, 0, 8'h12); pc(0, 0, 0, 0, 8'h11);
    req = 2'b01; addr = {7'h0, 7'h09}; rw = 2'b00; len = 4'h3; wdata = {32'h0, 32'h44332211};
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (gnt != 2'b00) req = 2'b00;
        if (eng_go && !eng_start) seen = 1'b1;
      end
      chk("xfer_reached", {63'h0, seen}, 64'h1);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_outs", {gnt, done, err, busy, eng_go, eng_start, eng_stop, eng_rd, eng_mack, eng_tx},
        '0);
    chk("midrst_rdata", {32'h0, rdata}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_rst", {62'h0, done}, 64'h0);

    chk("cmd_queue_empty", exp_cmd.size(), 0);
    chk("fin_queue_empty", exp_fin.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 The module SHALL have one parameter: TIMEOUT, default 20000, the number of cycles allowed while waiting for eng_done before a transaction is aborted.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 req  in  2  transaction request; bit N belongs to requester N.
REQ-005 addr  in  14  7-bit slave addresses, packed as {addr1, addr0}.
REQ-006 rw  in  2  per-requester direction; 1 = read, 0 = write.
REQ-007 len  in  4  per-requester byte count minus 1 (1-4 bytes), packed as {len1, len0}.
REQ-008 wdata  in  64  per-requester write bytes, packed as {wdata1, wdata0}; byte 0 is bits [7:0] and is sent first.
REQ-009 gnt  out  2  one-hot; high for the whole owned transaction.
REQ-010 done  out  2  one-cycle completion pulse per requester.
REQ-011 err  out  2  one-cycle error pulse; coincides with done.
REQ-012 rdata  out  32  read bytes; byte i is bits [8i+7:8i].
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 eng_go  out  1  one-cycle command strobe to the byte engine.
REQ-015 eng_start, eng_stop, eng_rd, eng_mack  out  1 each  per command: START before the byte, STOP after the byte, read byte, master ack bit (0 = ACK).
REQ-016 eng_tx  out  8  byte to transmit.
REQ-017 eng_done  in  1  engine command-complete pulse.
REQ-018 eng_rx  in  8  received byte; valid while eng_done is high.
REQ-019 eng_nack  in  1  slave NACK; valid while eng_done is high.

Function
REQ-020 States SHALL be IDLE, ADDR, XFER, STOP and FIN; each of ADDR, XFER and STOP issues one eng_go on entry or per byte, then waits for eng_done.
REQ-021 Arbitration in IDLE SHALL be round-robin:
- A sole requester wins.
- When both request, the one not granted most recently wins.
- After reset, requester 0 has priority.
REQ-022 Grant timing and latching:
- gnt[w] SHALL rise the cycle after req[w] is sampled in IDLE.
- addr, rw, len and wdata of the winner SHALL be latched in that same cycle.
- Input changes after latching SHALL be ignored.
REQ-023 ADDR SHALL issue its eng_go the cycle after gnt rises, with eng_start=1, eng_stop=0, eng_rd=0 and eng_tx={addr,rw}.
- eng_done with eng_nack=1 -> STOP, error flagged.
- eng_done with eng_nack=0 -> XFER, byte index 0.
REQ-024 XFER SHALL issue eng_go for byte index i one cycle after the previous eng_done:
- Write: eng_tx = wdata byte i, eng_rd=0.
- Read: eng_rd=1, eng_tx=0, eng_mack=0 for every byte except the last, which gets eng_mack=1.
- eng_stop=1 only on the last byte (i = len).
REQ-025 In XFER, on each eng_done:
- Read: store eng_rx into rdata byte i.
- Write with eng_nack=1 on a non-last byte -> STOP, error flagged.
- Write with eng_nack=1 on the last byte -> FIN, error flagged (STOP already issued).
- After the last byte completes -> FIN.
REQ-026 When a read is granted, rdata SHALL clear to 0, so bytes above len read as 0. Write transactions SHALL leave rdata unchanged.
REQ-027 STOP SHALL issue one eng_go with eng_stop=1, eng_start=0, eng_rd=0 and eng_tx=0, then go to FIN on eng_done.
REQ-028 FIN SHALL last exactly one cycle, in which:
- done[w] pulses, and err[w] pulses if an error was flagged.
- gnt drops, the round-robin pointer updates, and the next state is IDLE.
- A new grant SHALL NOT occur earlier than the cycle after FIN.
REQ-029 Timeout:
- A cycle counter SHALL clear on every eng_go and count while waiting.
- Reaching TIMEOUT with no eng_done -> FIN with error, with no STOP issued.
REQ-030 eng_done SHALL be ignored outside the wait phases and in the same cycle as eng_go.
REQ-031 A requester dropping req during its grant SHALL NOT abort the transaction.
REQ-032 Minimum latency, 1-byte write with a zero-delay engine (eng_done the cycle after eng_go): req sampled at cycle 0 -> gnt at 1, address eng_go at 2, data eng_go at 4, done at 6.

Reset
REQ-033 While reset is low on a clock edge, the block SHALL:
- go to state IDLE;
- drive gnt, done, err, busy and every eng_* output to 0 and rdata to 0;
- clear the timeout counter and give requester 0 priority.
REQ-034 Reset asserted mid-transaction SHALL abort immediately, with no STOP command and no done/err pulse.

Verification
REQ-035 Write: req0, addr0=0x27, len0=1, wdata0=0x0000A55A, no NACK -> eng_tx sequence 0x4E, 0x5A, 0xA5; eng_stop only on 0xA5; done[0] pulses, err[0]=0.
REQ-036 Read: req1, addr1=0x48, rw1=1, len1=1, engine returns 0x19 then 0x80 -> address byte 0x91; eng_mack 0 then 1; rdata=0x00008019; done[1] pulses.
REQ-037 Contention: both req held high from reset -> grant order 0, 1, 0, 1 with no overlap of gnt bits.
REQ-038 Address NACK: eng_nack=1 on the address byte -> exactly one stop-only command, then done and err pulse in the same cycle; no data commands issued.
REQ-039 Timeout and reset:
- eng_done withheld for TIMEOUT cycles -> err pulses, state returns to IDLE.
- Separately, reset=0 mid-XFER -> all outputs 0 on the next edge.
